// File: rtl/hc_dpram_endpoint_if.sv
// Xillybus seekable stream pair (address, write and read strobes) between core and user endpoint.
// Latency: none, this is wiring only; read data follows rden by one cycle in the endpoint.
// Backpressure: the endpoint drives full/empty/eof back to the core through the slave modport.
interface hc_dpram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] user_hc_dpram_addr;
  logic              user_hc_dpram_addr_update;
  logic              user_w_hc_dpram_open;
  logic              user_w_hc_dpram_wren;
  logic [DATA_W-1:0] user_w_hc_dpram_data;
  logic              user_w_hc_dpram_full;
  logic              user_r_hc_dpram_open;
  logic              user_r_hc_dpram_rden;
  logic [DATA_W-1:0] user_r_hc_dpram_data;
  logic              user_r_hc_dpram_empty;
  logic              user_r_hc_dpram_eof;

  // Core side: drives seeks and strobes, observes data and flow-control flags.
  modport master (
    output user_hc_dpram_addr, user_hc_dpram_addr_update,
    output user_w_hc_dpram_open, user_w_hc_dpram_wren, user_w_hc_dpram_data,
    input  user_w_hc_dpram_full,
    output user_r_hc_dpram_open, user_r_hc_dpram_rden,
    input  user_r_hc_dpram_data, user_r_hc_dpram_empty, user_r_hc_dpram_eof
  );

  // Endpoint side: mirror image of the core.
  modport slave (
    input  user_hc_dpram_addr, user_hc_dpram_addr_update,
    input  user_w_hc_dpram_open, user_w_hc_dpram_wren, user_w_hc_dpram_data,
    output user_w_hc_dpram_full,
    input  user_r_hc_dpram_open, user_r_hc_dpram_rden,
    output user_r_hc_dpram_data, user_r_hc_dpram_empty, user_r_hc_dpram_eof
  );
endinterface

// File: rtl/hc_dpram_endpoint.sv
// Seekable Xillybus hc_dpram responder: dual-port RAM, host stream port plus application port.
// Latency: host read data and app_rdata one cycle after the strobe/address; writes land at the edge.
// Backpressure: full is never raised; empty follows read open (and EOF when HC_DPRAM_READ_EOF_EN).
//
// Build option HC_DPRAM_READ_EOF_EN: a read at the last word parks the pointer there and raises
// empty/eof until the next seek or read-open rising edge. Without it the read stream wraps forever.
module hc_dpram_endpoint #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              bus_clk,
  input  logic              trn_reset_n,
  hc_dpram_if.slave         xb,
  input  logic [ADDR_W-1:0] app_addr,
  input  logic              app_wren,
  input  logic [DATA_W-1:0] app_wdata,
  output logic [DATA_W-1:0] app_rdata,
  output logic              app_host_wr,
  input  logic              app_clear,
  output logic              app_collision
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage is deliberately not reset; only the control path is.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              w_open_q, w_open_d;
  logic              r_open_q, r_open_d;
  logic              empty_q, empty_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] app_rdata_q, app_rdata_d;
  logic              host_wr_q, host_wr_d;
  logic              collision_q, collision_d;

  logic host_wr;
  logic host_rd;
  logic w_open_rise;
  logic r_open_rise;
  logic app_hit;
  logic app_wr;

`ifdef HC_DPRAM_READ_EOF_EN
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic eof_q, eof_d;
  logic rd_at_last;
`endif

  // Qualify strobes with their open flags and resolve host/app write collisions.
  always_comb begin
    host_wr     = xb.user_w_hc_dpram_wren & xb.user_w_hc_dpram_open;
`ifdef HC_DPRAM_READ_EOF_EN
    host_rd     = xb.user_r_hc_dpram_rden & xb.user_r_hc_dpram_open & ~eof_q;
    rd_at_last  = host_rd & (ptr_q == LAST);
`else
    host_rd     = xb.user_r_hc_dpram_rden & xb.user_r_hc_dpram_open;
`endif
    w_open_rise = xb.user_w_hc_dpram_open & ~w_open_q;
    r_open_rise = xb.user_r_hc_dpram_open & ~r_open_q;
    // Host owns the word when both sides write the same address in one cycle.
    app_hit     = host_wr & app_wren & (app_addr == ptr_q);
    app_wr      = app_wren & ~app_hit;
  end

  // Next-state for the shared pointer, flags and registered read ports.
  always_comb begin
    ptr_d       = ptr_q;
    w_open_d    = xb.user_w_hc_dpram_open;
    r_open_d    = xb.user_r_hc_dpram_open;
    empty_d     = ~xb.user_r_hc_dpram_open;
    rdata_d     = rdata_q;
    app_rdata_d = mem[app_addr];
    host_wr_d   = host_wr_q;
    collision_d = app_hit;

    // A seek overrides everything, then a fresh open rewinds, then the access advances.
    if (xb.user_hc_dpram_addr_update) begin
      ptr_d = xb.user_hc_dpram_addr;
    end else if (w_open_rise || r_open_rise) begin
      ptr_d = '0;
    end else if (host_wr || host_rd) begin
`ifdef HC_DPRAM_READ_EOF_EN
      ptr_d = rd_at_last ? ptr_q : ptr_q + ADDR_W'(1);
`else
      ptr_d = ptr_q + ADDR_W'(1);
`endif
    end

    // Combinational array read before the edge's write gives read-first behaviour.
    if (host_rd) begin
      rdata_d = mem[ptr_q];
    end

    // Set beats clear when both happen together.
    if (host_wr) begin
      host_wr_d = 1'b1;
    end else if (app_clear) begin
      host_wr_d = 1'b0;
    end
  end

`ifdef HC_DPRAM_READ_EOF_EN
  // End-of-stream latch: armed by the read at the last word, dropped by a seek or reopen.
  always_comb begin
    eof_d = eof_q;
    if (xb.user_hc_dpram_addr_update || r_open_rise) begin
      eof_d = 1'b0;
    end else if (rd_at_last) begin
      eof_d = 1'b1;
    end
  end

  // End-of-stream flag register.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      eof_q <= 1'b0;
    end else begin
      eof_q <= eof_d;
    end
  end
`endif

  // Control and output registers.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      ptr_q       <= '0;
      w_open_q    <= 1'b0;
      r_open_q    <= 1'b0;
      empty_q     <= 1'b1;
      rdata_q     <= '0;
      app_rdata_q <= '0;
      host_wr_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      w_open_q    <= w_open_d;
      r_open_q    <= r_open_d;
      empty_q     <= empty_d;
      rdata_q     <= rdata_d;
      app_rdata_q <= app_rdata_d;
      host_wr_q   <= host_wr_d;
      collision_q <= collision_d;
    end
  end

  // RAM write ports; app_wr is already masked on an address clash with the host.
  always_ff @(posedge bus_clk) begin
    if (host_wr) begin
      mem[ptr_q] <= xb.user_w_hc_dpram_data;
    end
    if (app_wr) begin
      mem[app_addr] <= app_wdata;
    end
  end

  assign xb.user_w_hc_dpram_full = 1'b0;
  assign xb.user_r_hc_dpram_data = rdata_q;
`ifdef HC_DPRAM_READ_EOF_EN
  assign xb.user_r_hc_dpram_empty = empty_q | eof_q;
  assign xb.user_r_hc_dpram_eof   = eof_q;
`else
  assign xb.user_r_hc_dpram_empty = empty_q;
  assign xb.user_r_hc_dpram_eof   = 1'b0;
`endif
  assign app_rdata     = app_rdata_q;
  assign app_host_wr   = host_wr_q;
  assign app_collision = collision_q;

endmodule

// File: tb/tb_hc_dpram_endpoint.sv
// Directed bench for hc_dpram_endpoint: seek/stream writes and reads, collisions, wrap, EOF, reset.
// Latency: all checks sampled 1ns after the rising edge that registers the result.
// Backpressure: full must stay low; empty/eof checked against open and end-of-stream handling.
module tb_hc_dpram_endpoint;
  logic        bus_clk;
  logic        trn_reset_n;
  logic [4:0]  app_addr;
  logic        app_wren;
  logic [31:0] app_wdata;
  logic [31:0] app_rdata;
  logic        app_host_wr;
  logic        app_clear;
  logic        app_collision;

  int n_tests = 0;
  int n_fail  = 0;

  hc_dpram_if #(.DATA_W(32), .ADDR_W(5)) xb ();

  hc_dpram_endpoint #(.DATA_W(32), .ADDR_W(5)) dut (
    .bus_clk       (bus_clk),
    .trn_reset_n   (trn_reset_n),
    .xb            (xb),
    .app_addr      (app_addr),
    .app_wren      (app_wren),
    .app_wdata     (app_wdata),
    .app_rdata     (app_rdata),
    .app_host_wr   (app_host_wr),
    .app_clear     (app_clear),
    .app_collision (app_collision)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic seek(input logic [4:0] a);
    xb.user_hc_dpram_addr        = a;
    xb.user_hc_dpram_addr_update = 1'b1;
    tick();
    xb.user_hc_dpram_addr_update = 1'b0;
  endtask

  task automatic host_write(input logic [31:0] d);
    xb.user_w_hc_dpram_wren = 1'b1;
    xb.user_w_hc_dpram_data = d;
    tick();
    xb.user_w_hc_dpram_wren = 1'b0;
  endtask

  task automatic app_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
    app_addr = a;
    tick();
    check(tag, app_rdata, exp);
  endtask

  initial begin
    trn_reset_n                  = 1'b0;
    xb.user_hc_dpram_addr        = '0;
    xb.user_hc_dpram_addr_update = 1'b0;
    xb.user_w_hc_dpram_open      = 1'b0;
    xb.user_w_hc_dpram_wren      = 1'b0;
    xb.user_w_hc_dpram_data      = '0;
    xb.user_r_hc_dpram_open      = 1'b0;
    xb.user_r_hc_dpram_rden      = 1'b0;
    app_addr  = '0;
    app_wren  = 1'b0;
    app_wdata = '0;
    app_clear = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_rdata", xb.user_r_hc_dpram_data, 32'h0);
    check("rst_app_rdata", app_rdata, 32'h0);
    check("rst_full", {31'd0, xb.user_w_hc_dpram_full}, 32'd0);
    check("rst_empty", {31'd0, xb.user_r_hc_dpram_empty}, 32'd1);
    check("rst_eof", {31'd0, xb.user_r_hc_dpram_eof}, 32'd0);
    check("rst_host_wr", {31'd0, app_host_wr}, 32'd0);
    check("rst_collision", {31'd0, app_collision}, 32'd0);

    // Open both streams
    trn_reset_n             = 1'b1;
    xb.user_w_hc_dpram_open = 1'b1;
    xb.user_r_hc_dpram_open = 1'b1;
    tick();
    check("open_empty", {31'd0, xb.user_r_hc_dpram_empty}, 32'd0);

    // Stream four words from address 0, then one more to prove ptr=4
    seek(5'd0);
    for (int i = 0; i < 4; i++) host_write(32'hA0 + 32'(i));
    check("host_wr_set", {31'd0, app_host_wr}, 32'd1);
    check("full_low", {31'd0, xb.user_w_hc_dpram_full}, 32'd0);
    host_write(32'h44);
    app_read("ram0", 5'd0, 32'hA0);
    app_read("ram1", 5'd1, 32'hA1);
    app_read("ram2", 5'd2, 32'hA2);
    app_read("ram3", 5'd3, 32'hA3);
    app_read("ptr4", 5'd4, 32'h44);

    // Seek to 2 and stream two reads
    seek(5'd2);
    xb.user_r_hc_dpram_rden = 1'b1;
    tick();
    check("rd_a2", xb.user_r_hc_dpram_data, 32'hA2);
    tick();
    check("rd_a3", xb.user_r_hc_dpram_data, 32'hA3);
    xb.user_r_hc_dpram_rden = 1'b0;
    app_read("app_rd3", 5'd3, 32'hA3);

    // Same-address collision: host wins, collision pulses once
    seek(5'd5);
    xb.user_w_hc_dpram_wren = 1'b1;
    xb.user_w_hc_dpram_data = 32'h11;
    app_wren  = 1'b1;
    app_addr  = 5'd5;
    app_wdata = 32'h22;
    tick();
    xb.user_w_hc_dpram_wren = 1'b0;
    app_wren = 1'b0;
    check("coll_pulse", {31'd0, app_collision}, 32'd1);
    tick();
    check("coll_drop", {31'd0, app_collision}, 32'd0);
    app_read("coll_ram5", 5'd5, 32'h11);

    // App write elsewhere is not a collision
    app_wren  = 1'b1;
    app_addr  = 5'd10;
    app_wdata = 32'h5A;
    tick();
    app_wren = 1'b0;
    check("nocoll", {31'd0, app_collision}, 32'd0);
    app_read("app_wr10", 5'd10, 32'h5A);

    // app_clear alone clears; with a host write the set wins (ptr=6 here)
    app_clear = 1'b1;
    tick();
    app_clear = 1'b0;
    check("clear", {31'd0, app_host_wr}, 32'd0);
    app_clear = 1'b1;
    host_write(32'h66);
    app_clear = 1'b0;
    check("set_wins", {31'd0, app_host_wr}, 32'd1);

    // Wrap from 31 to 0
    seek(5'd31);
    host_write(32'hFF);
    host_write(32'hEE);
    app_read("wrap31", 5'd31, 32'hFF);
    app_read("wrap0", 5'd0, 32'hEE);

    // Read and write together at 6: read returns pre-write data
    seek(5'd6);
    xb.user_w_hc_dpram_wren = 1'b1;
    xb.user_w_hc_dpram_data = 32'h99;
    xb.user_r_hc_dpram_rden = 1'b1;
    tick();
    xb.user_w_hc_dpram_wren = 1'b0;
    xb.user_r_hc_dpram_rden = 1'b0;
    check("rd_first", xb.user_r_hc_dpram_data, 32'h66);
    app_read("wr_after_rd", 5'd6, 32'h99);

    // Strobes with file closed are ignored
    seek(5'd1);
    xb.user_w_hc_dpram_open = 1'b0;
    tick();
    host_write(32'h33);
    app_read("closed_wr", 5'd1, 32'hA1);
    xb.user_w_hc_dpram_open = 1'b1;
    tick();
    xb.user_r_hc_dpram_open = 1'b0;
    tick();
    check("closed_empty", {31'd0, xb.user_r_hc_dpram_empty}, 32'd1);
    xb.user_r_hc_dpram_rden = 1'b1;
    tick();
    xb.user_r_hc_dpram_rden = 1'b0;
    check("closed_rd", xb.user_r_hc_dpram_data, 32'h66);
    xb.user_r_hc_dpram_open = 1'b1;
    tick();
    check("reopen_empty", {31'd0, xb.user_r_hc_dpram_empty}, 32'd0);

    // End of stream
    seek(5'd30);
    host_write(32'h30);
    seek(5'd30);
    xb.user_r_hc_dpram_rden = 1'b1;
    tick();
    check("eof_rd30", xb.user_r_hc_dpram_data, 32'h30);
    check("eof_rd30_empty", {31'd0, xb.user_r_hc_dpram_empty}, 32'd0);
    tick();
    check("eof_rd31", xb.user_r_hc_dpram_data, 32'hFF);
`ifdef HC_DPRAM_READ_EOF_EN
    check("eof_set", {31'd0, xb.user_r_hc_dpram_eof}, 32'd1);
    check("eof_empty", {31'd0, xb.user_r_hc_dpram_empty}, 32'd1);
    tick();
    xb.user_r_hc_dpram_rden = 1'b0;
    check("eof_rd_ignored", xb.user_r_hc_dpram_data, 32'hFF);
    check("eof_held", {31'd0, xb.user_r_hc_dpram_eof}, 32'd1);
    seek(5'd0);
    check("eof_clr", {31'd0, xb.user_r_hc_dpram_eof}, 32'd0);
    check("eof_clr_empty", {31'd0, xb.user_r_hc_dpram_empty}, 32'd0);
`else
    check("noeof_eof", {31'd0, xb.user_r_hc_dpram_eof}, 32'd0);
    check("noeof_empty", {31'd0, xb.user_r_hc_dpram_empty}, 32'd0);
    tick();
    xb.user_r_hc_dpram_rden = 1'b0;
    check("noeof_wrap", xb.user_r_hc_dpram_data, 32'hEE);
`endif

    // Reset in the middle of a read burst
    seek(5'd0);
    xb.user_r_hc_dpram_rden = 1'b1;
    tick();
    check("burst0", xb.user_r_hc_dpram_data, 32'hEE);
    tick();
    check("burst1", xb.user_r_hc_dpram_data, 32'hA1);
    trn_reset_n = 1'b0;
    #2;
    check("midrst_rdata", xb.user_r_hc_dpram_data, 32'h0);
    check("midrst_empty", {31'd0, xb.user_r_hc_dpram_empty}, 32'd1);
    check("midrst_host_wr", {31'd0, app_host_wr}, 32'd0);
    check("midrst_app_rdata", app_rdata, 32'h0);
    xb.user_r_hc_dpram_rden = 1'b0;
    tick();
    trn_reset_n = 1'b1;
    tick();
    check("post_rst_empty", {31'd0, xb.user_r_hc_dpram_empty}, 32'd0);
    xb.user_r_hc_dpram_rden = 1'b1;
    tick();
    xb.user_r_hc_dpram_rden = 1'b0;
    check("post_rst_ptr0", xb.user_r_hc_dpram_data, 32'hEE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
